// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the IFU/LSU memory arbiter
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding IFU/LSU arbiter for one memory port, LSU priority with IFU starvation guard
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic owner_lsu;
  logic [CNT_W-1:0] starve_cnt;
  logic starved, grant_lsu, grant_ifu, resp;
  // grant decision in IDLE; readies depend only on registered state and request valids
  always_comb begin
    starved = starve_cnt == CNT_W'(STARVE_LIMIT);
    grant_lsu = state == IDLE && bus.lsu_req_valid && !(bus.ifu_req_valid && starved);
    grant_ifu = state == IDLE && bus.ifu_req_valid && !grant_lsu;
    resp = state == WAIT && bus.mem_resp_valid;
  end
  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = state == ISSUE;
  assign bus.ifu_resp_valid = resp && !owner_lsu;
  assign bus.lsu_resp_valid = resp && owner_lsu;
  assign bus.ifu_rdata      = bus.ifu_resp_valid ? bus.mem_rdata : '0;
  assign bus.lsu_rdata      = bus.lsu_resp_valid ? bus.mem_rdata : '0;
  // transaction FSM: latch the granted payload, hold it through issue, route the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner_lsu <= 1'b0;
      starve_cnt <= '0;
      bus.mem_addr <= '0;
      bus.mem_wen <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
    end else begin
      case (state)
        IDLE: if (grant_lsu || grant_ifu) begin
          state <= ISSUE;
          owner_lsu <= grant_lsu;
          bus.mem_addr <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
          bus.mem_wen <= grant_lsu && bus.lsu_wen;
          bus.mem_wdata <= grant_lsu ? bus.lsu_wdata : '0;
          bus.mem_wmask <= grant_lsu ? bus.lsu_wmask : '0;
          starve_cnt <= grant_ifu ? '0 : (bus.ifu_req_valid && !starved) ? starve_cnt + 1'b1 : starve_cnt;
        end
        ISSUE: if (bus.mem_req_ready) state <= WAIT;
        WAIT: if (bus.mem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
